// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel filter: line-buffered window, 2-stage pipeline, bypass/grey/binary output.
// Optional SOBEL_EDGE_COUNT_EN adds a per-frame edge_count output.
module sobel_stream_filter #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int ROW_W  = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            mode,
    input  logic [DATA_W-1:0]     thresh,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [3*DATA_W-1:0]   s_data,
    input  logic                  s_sof,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [3*DATA_W-1:0]   m_data,
    output logic                  m_edge,
    output logic                  m_sof
`ifdef SOBEL_EDGE_COUNT_EN
    ,
    output logic [31:0]           edge_count
`endif
);
    localparam int PW = 3 * DATA_W;
    localparam int GW = DATA_W + 3;
    localparam int MW = DATA_W + 4;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [ROW_W-1:0] LAST_COL = ROW_W'(IMG_W - 1);

    logic advance, accept;
    assign advance = !m_valid || m_ready;
    assign s_ready = advance;
    assign accept  = s_valid && advance;

    logic [ROW_W-1:0] row, col, pos_row, pos_col;
    logic [AW-1:0]    idx;
    logic [DATA_W-1:0] px, top_c, mid_c;

    // s_sof places the accepted pixel at the origin regardless of counter state
    assign pos_row = s_sof ? '0 : row;
    assign pos_col = s_sof ? '0 : col;
    assign idx     = pos_col[AW-1:0];
    assign px      = s_data[DATA_W-1:0];

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    assign mid_c = lb0[idx];
    assign top_c = lb1[idx];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[idx] <= lb0[idx];
            lb0[idx] <= px;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (pos_col == LAST_COL) begin
                col <= '0;
                row <= (&pos_row) ? pos_row : pos_row + 1'b1;
            end else begin
                col <= pos_col + 1'b1;
                row <= pos_row;
            end
        end
    end

    // columns c-2 and c-1 of the three window rows; column c comes straight from the buffers
    logic [DATA_W-1:0] wt [2];
    logic [DATA_W-1:0] wm [2];
    logic [DATA_W-1:0] wb [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                wt[i] <= '0;
                wm[i] <= '0;
                wb[i] <= '0;
            end
        end else if (accept) begin
            wt[0] <= wt[1]; wt[1] <= top_c;
            wm[0] <= wm[1]; wm[1] <= mid_c;
            wb[0] <= wb[1]; wb[1] <= px;
        end
    end

    logic signed [GW-1:0] e [9];
    logic signed [GW-1:0] gx, gy;

    always_comb begin
        e[0] = $signed({3'b000, wt[0]}); e[1] = $signed({3'b000, wt[1]}); e[2] = $signed({3'b000, top_c});
        e[3] = $signed({3'b000, wm[0]}); e[4] = $signed({3'b000, wm[1]}); e[5] = $signed({3'b000, mid_c});
        e[6] = $signed({3'b000, wb[0]}); e[7] = $signed({3'b000, wb[1]}); e[8] = $signed({3'b000, px});
        gx = (e[2] - e[0]) + ((e[5] - e[3]) <<< 1) + (e[8] - e[6]);
        gy = (e[0] - e[6]) + ((e[1] - e[7]) <<< 1) + (e[2] - e[8]);
    end

    logic                 v1, sof1, bord1;
    logic [1:0]           mode1;
    logic [DATA_W-1:0]    th1;
    logic [PW-1:0]        pix1;
    logic signed [GW-1:0] gx1, gy1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sof1  <= 1'b0;
            bord1 <= 1'b1;
            mode1 <= '0;
            th1   <= '0;
            pix1  <= '0;
            gx1   <= '0;
            gy1   <= '0;
        end else if (advance) begin
            v1    <= s_valid;
            sof1  <= s_valid && s_sof;
            bord1 <= (pos_row < ROW_W'(2)) || (pos_col < ROW_W'(2));
            mode1 <= mode;
            th1   <= thresh;
            pix1  <= s_data;
            gx1   <= gx;
            gy1   <= gy;
        end
    end

    logic [GW-1:0]     ax, ay;
    logic [MW-1:0]     mag;
    logic [DATA_W-1:0] sat;
    logic              edg;

    always_comb begin
        ax  = gx1[GW-1] ? -gx1 : gx1;
        ay  = gy1[GW-1] ? -gy1 : gy1;
        mag = {1'b0, ax} + {1'b0, ay};
        sat = (|mag[MW-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
        if (bord1) sat = '0;
        edg = sat > th1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_edge  <= 1'b0;
            m_sof   <= 1'b0;
        end else if (advance) begin
            m_valid <= v1;
            m_sof   <= sof1;
            case (mode1)
                2'd1: begin m_data <= {3{sat}};       m_edge <= edg;  end
                2'd2: begin m_data <= edg ? '1 : '0;  m_edge <= edg;  end
                default: begin m_data <= pix1;        m_edge <= 1'b0; end
            endcase
        end
    end

`ifdef SOBEL_EDGE_COUNT_EN
    logic [31:0] ecnt;

    // an m_sof handshake publishes the finished frame's total and starts the next at this pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ecnt       <= '0;
            edge_count <= '0;
        end else if (m_valid && m_ready) begin
            if (m_sof) begin
                edge_count <= ecnt;
                ecnt       <= {31'b0, m_edge};
            end else if (m_edge && !(&ecnt)) begin
                ecnt <= ecnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter on an 8x6 frame; frame configurations come from a vector table.
module tb_sobel_stream_filter;
    localparam int DW = 8;
    localparam int IW = 8;
    localparam int IH = 6;
    localparam int NPIX = IW * IH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [DW-1:0] thresh;
    logic          s_valid, s_ready, s_sof;
    logic [23:0]   s_data;
    logic          m_valid, m_ready, m_edge, m_sof;
    logic [23:0]   m_data;
`ifdef SOBEL_EDGE_COUNT_EN
    logic [31:0]   edge_count;
`endif

    sobel_stream_filter #(.DATA_W(DW), .IMG_W(IW), .ROW_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .thresh(thresh),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_edge(m_edge), .m_sof(m_sof)
`ifdef SOBEL_EDGE_COUNT_EN
        , .edge_count(edge_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  md;
        logic [7:0]  th;
        logic [7:0]  lo;
        logic [7:0]  hi;
        bit          byp;
        logic [23:0] e_data;
        logic        e_edge;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [25:0] outq [NPIX];
    int n_out;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [23:0] px(input int k, input logic [7:0] lo, input logic [7:0] hi, input bit pat3);
        int r, c;
        logic [7:0] ch0;
        r = k / IW;
        c = k % IW;
        if (pat3) ch0 = (c >= 2 && c <= 6) ? 8'hFF : 8'h00;
        else      ch0 = (c < 4) ? lo : hi;
        return {8'(c) ^ 8'h5A, 8'(r) + 8'h30, ch0};
    endfunction

    // streams one frame and captures every output handshake into outq
    task automatic run_frame(input logic [1:0] md, input logic [7:0] th, input logic [7:0] lo,
                             input logic [7:0] hi, input bit pat3, input bit rnd);
        int i_in, cyc;
        i_in = 0;
        n_out = 0;
        cyc = 0;
        for (int k = 0; k < NPIX; k++) outq[k] = '0;
        while (n_out < NPIX && cyc < 2000) begin
            @(negedge clk);
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (i_in < NPIX) begin
                s_valid = 1'b1;
                s_data  = px(i_in, lo, hi, pat3);
                s_sof   = (i_in == 0);
                mode    = md;
                thresh  = th;
            end else begin
                s_valid = 1'b0;
                s_sof   = 1'b0;
            end
            #1;
            chk("s_ready_rule", {31'b0, s_ready}, {31'b0, !(m_valid && !m_ready)});
            if (m_valid && m_ready) begin
                outq[n_out] = {m_sof, m_edge, m_data};
                n_out++;
            end
            if (s_valid && s_ready) i_in++;
            cyc++;
        end
        chk("frame_timeout_outputs", n_out, NPIX);
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic check_frame(input vec_t v);
        logic [23:0] ed;
        logic        ee;
        int r, c;
        for (int k = 0; k < NPIX; k++) begin
            r = k / IW;
            c = k % IW;
            if (v.byp) begin
                ed = px(k, v.lo, v.hi, 1'b0);
                ee = 1'b0;
            end else if (r >= 2 && (c == 4 || c == 5)) begin
                ed = v.e_data;
                ee = v.e_edge;
            end else begin
                ed = 24'h0;
                ee = 1'b0;
            end
            chk($sformatf("%s_r%0d_c%0d", v.name, r, c), {6'b0, outq[k]}, {6'b0, (k == 0), ee, ed});
        end
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{"grey_step",    2'd1, 8'd60,  8'h00, 8'hFF, 1'b0, 24'hFFFFFF, 1'b1};
        vecs[1]  = '{"bin_flat",     2'd2, 8'd0,   8'd100, 8'd100, 1'b0, 24'h000000, 1'b0};
        vecs[2]  = '{"bin_step",     2'd2, 8'd60,  8'h00, 8'hFF, 1'b0, 24'hFFFFFF, 1'b1};
        vecs[3]  = '{"grey_thmax",   2'd1, 8'hFF,  8'h00, 8'hFF, 1'b0, 24'hFFFFFF, 1'b0};
        vecs[4]  = '{"grey_mid",     2'd1, 8'h3F,  8'h10, 8'h20, 1'b0, 24'h404040, 1'b1};
        vecs[5]  = '{"grey_theq",    2'd1, 8'h40,  8'h10, 8'h20, 1'b0, 24'h404040, 1'b0};
        vecs[6]  = '{"bin_mid",      2'd2, 8'h3F,  8'h10, 8'h20, 1'b0, 24'hFFFFFF, 1'b1};
        vecs[7]  = '{"bin_theq",     2'd2, 8'h40,  8'h10, 8'h20, 1'b0, 24'h000000, 1'b0};
        vecs[8]  = '{"grey_sat",     2'd1, 8'hFE,  8'h00, 8'h50, 1'b0, 24'hFFFFFF, 1'b1};
        vecs[9]  = '{"bypass_m3",    2'd3, 8'h00,  8'h00, 8'hFF, 1'b1, 24'h000000, 1'b0};
        vecs[10] = '{"bypass_m0",    2'd0, 8'h10,  8'h00, 8'hFF, 1'b1, 24'h000000, 1'b0};

        rst_n = 1'b0; mode = 2'd0; thresh = '0;
        s_valid = 1'b0; s_data = '0; s_sof = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("rst_m_data",  {8'b0, m_data},   32'd0);
        chk("rst_m_edge",  {31'b0, m_edge},  32'd0);
        chk("rst_m_sof",   {31'b0, m_sof},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_s_ready", {31'b0, s_ready}, 32'd1);

        // single bypass pixel: visible on m_* two edges after the accepting edge
        @(negedge clk);
        s_valid = 1'b1; s_data = 24'h123456; s_sof = 1'b1; mode = 2'd0; thresh = 8'd0;
        @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0;
        #1;
        chk("lat_1clk_m_valid", {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        #1;
        chk("lat_2clk_m_valid", {31'b0, m_valid}, 32'd1);
        chk("lat_2clk_m_data",  {8'b0, m_data},   32'h123456);
        chk("lat_2clk_m_edge",  {31'b0, m_edge},  32'd0);
        chk("lat_2clk_m_sof",   {31'b0, m_sof},   32'd1);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_frame(vecs[i].md, vecs[i].th, vecs[i].lo, vecs[i].hi, 1'b0, 1'b0);
            check_frame(vecs[i]);
        end

        // backpressure: same expectations as the full-rate grey step frame
        run_frame(vecs[0].md, vecs[0].th, vecs[0].lo, vecs[0].hi, 1'b0, 1'b1);
        check_frame(vecs[0]);

        // reset pulse part-way into row 3, then a fresh frame
        for (int k = 0; k < 3 * IW + 3; k++) begin
            @(negedge clk);
            m_ready = 1'b1;
            s_valid = 1'b1; s_data = px(k, 8'h00, 8'hFF, 1'b0); s_sof = (k == 0);
            mode = 2'd1; thresh = 8'd60;
        end
        @(negedge clk);
        s_valid = 1'b0; s_sof = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", {31'b0, m_valid}, 32'd0);
        chk("midrst_m_data",  {8'b0, m_data},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(vecs[0].md, vecs[0].th, vecs[0].lo, vecs[0].hi, 1'b0, 1'b0);
        check_frame(vecs[0]);

`ifdef SOBEL_EDGE_COUNT_EN
        run_frame(2'd1, 8'd60, 8'h00, 8'h00, 1'b1, 1'b0);
        run_frame(2'd1, 8'd60, 8'h00, 8'hFF, 1'b0, 1'b0);
        chk("edge_count_12", edge_count, 32'd12);
`endif

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sobel_stream_filter.md
Name: sobel_stream_filter

Overview:
- Parametrised successor to the fixed 3x3 Sobel pixel stage.
- Accepts a raster pixel stream over a valid/ready handshake.
- Builds the 3x3 window internally from two line buffers.
- Emits a per-pixel gradient magnitude, an edge flag and a runtime-selectable output mode; sits between video input capture and the projection/output stage.

Parameters:
- DATA_W, 8, bits per colour channel; pixel bus is 3*DATA_W.
- IMG_W, 640, active pixels per line; line-buffer depth.
- ROW_W, 11, row/column counter width; must satisfy 2^ROW_W > IMG_W.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  0 bypass, 1 grey magnitude, 2 binary edge, 3 treated as bypass; sampled per accepted pixel.
- thresh  in  DATA_W  edge threshold; sampled per accepted pixel.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  input accepted when s_valid && s_ready.
- s_data  in  3*DATA_W  input pixel; channel 0 = [DATA_W-1:0] feeds the filter.
- s_sof  in  1  first pixel of frame, qualified by s_valid.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream ready.
- m_data  out  3*DATA_W  output pixel.
- m_edge  out  1  magnitude > thresh (forced 0 in bypass).
- m_sof  out  1  sof flag delayed with its pixel.

Behaviour:
- Reset: m_valid=0, m_data=0, m_edge=0, m_sof=0, row=col=0; s_ready=1 while out of reset.
  - Line-buffer RAM contents are not cleared; border masking hides stale data.
- Handshake:
  - advance = !m_valid || m_ready; s_ready = advance (combinational).
  - m_* hold stable while m_valid && !m_ready.
  - No pixel is dropped or duplicated.
- Pipeline: 2 register stages, both enabled by advance.
  - Accepted pixel appears on m_* 2 advancing cycles later; full throughput is 1 pixel/clk.
  - Bubbles propagate as m_valid=0.
- Position counters update on accept:
  - s_sof forces the accepted pixel to row=0, col=0.
  - Otherwise col increments; at col=IMG_W-1 it wraps to 0 and row increments.
  - row saturates at 2^ROW_W-1.
- Window:
  - Two IMG_W x DATA_W line buffers plus 3x3 shift registers.
  - Window for the current pixel covers rows r-2..r and cols c-2..c.
  - p0..p2 oldest row, p6..p8 current row; left-to-right within each row.
- Arithmetic (stage 1):
  - gx = (p2-p0) + 2(p5-p3) + (p8-p6).
  - gy = (p0-p6) + 2(p1-p7) + (p2-p8).
  - Both signed, DATA_W+3 bits, no overflow.
- Arithmetic (stage 2):
  - mag = |gx| + |gy|, unsigned DATA_W+4 bits.
  - sat = all-ones if any bit above DATA_W-1 is set, else mag[DATA_W-1:0].
  - edge = sat > thresh (strict).
- Border: if row<2 or col<2, sat=0 and edge=0.
- Output by mode:
  - Bypass: m_data = input pixel delayed 2 stages, m_edge=0.
  - Grey: sat replicated into all three channels.
  - Binary: all-ones if edge, else 0.
  - mode and thresh are captured with the pixel, so a change takes effect on the next accepted pixel only.
- Frame-size mismatch (sof early/late): counters resync on s_sof; no error flag.
- Reset mid-frame: in-flight pixels discarded; first pixels after reset are treated as border until row>=2.

Optional Feature:
- Macro SOBEL_EDGE_COUNT_EN.
- Defined:
  - Adds output port edge_count (32 bits) and an internal 32-bit counter that increments on each output handshake (m_valid && m_ready) with m_edge=1, saturating at all-ones.
  - When an output handshake carries m_sof=1, edge_count latches the counter total and the counter restarts at that pixel's edge value.
  - edge_count resets to 0.
- Undefined: no port, no counter.

Test Plan:
- Reset then mode=0, stream 0x123456 with m_ready=1 -> m_data=0x123456 exactly 2 clk after accept, m_edge=0.
- IMG_W=8, mode=1, frame of channel0=0 for cols 0-3 and 255 for cols 4-7, thresh=60 -> rows>=2 cols 4 and 5 give sat=0xFF, others 0; rows 0-1 all 0.
- mode=2, flat frame value 100, thresh=0 -> all outputs 0x000000, m_edge=0.
- Random m_ready (50%) with full-rate s_valid over a 8x6 frame -> output sequence identical to m_ready=1 run; s_ready low exactly when m_valid && !m_ready.
- Assert rst_n low mid-row 3 for 1 clk, then new s_sof -> m_valid=0 during reset; new frame rows 0-1 output 0.
- With SOBEL_EDGE_COUNT_EN, frame with 12 edge pixels followed by s_sof -> edge_count=12 on the second frame's m_sof handshake.
